acq_window_ctrl: RTL

Multi-shot acquisition window controller placed directly downstream of the trigger decoder. It consumes the one-cycle `trigger_start` pulse and opens a sample-capture window of programmable length after a programmable delay. It repeats this for a programmed number of laser shots, then reports completion. Its outputs gate the ADC sample path feeding the accumulation and FFT stages.

---
 rtl/acq_pkg.sv | 16 +
 rtl/acq_window_ctrl_if.sv | 36 +++
 rtl/acq_sat_counter.sv | 29 ++
 rtl/acq_window_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and default widths for the multi-shot acquisition window controller.
package acq_pkg;

    localparam int ACQ_CNT_W  = 16;
    localparam int ACQ_SHOT_W = 16;
    localparam int ACQ_MISS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_window_ctrl_if.sv
// Control/status bundle between the trigger/config side and the acquisition window controller.
interface acq_window_ctrl_if #(
    parameter int CNT_W  = acq_pkg::ACQ_CNT_W,
    parameter int SHOT_W = acq_pkg::ACQ_SHOT_W,
    parameter int MISS_W = acq_pkg::ACQ_MISS_W
) ();

    logic              arm;
    logic              abort;
    logic              trigger_start;
    logic [CNT_W-1:0]  delay_cfg;
    logic [CNT_W-1:0]  length_cfg;
    logic [SHOT_W-1:0] shots_cfg;

    logic              window_en;
    logic              first_sample;
    logic              last_sample;
    logic [CNT_W-1:0]  sample_idx;
    logic [SHOT_W-1:0] shot_idx;
    logic              busy;
    logic              acq_done;
    logic [MISS_W-1:0] missed_cnt;

    modport master (
        output arm, abort, trigger_start, delay_cfg, length_cfg, shots_cfg,
        input  window_en, first_sample, last_sample, sample_idx, shot_idx,
               busy, acq_done, missed_cnt
    );

    modport slave (
        input  arm, abort, trigger_start, delay_cfg, length_cfg, shots_cfg,
        output window_en, first_sample, last_sample, sample_idx, shot_idx,
               busy, acq_done, missed_cnt
    );

endinterface

// File: rtl/acq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module acq_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_cnt;

    // Count up on i_inc, stick at all-ones, clear on i_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/acq_window_ctrl.sv
// Multi-shot acquisition window controller: per trigger, waits the latched delay,
// then opens a capture window of the latched length; repeats for the latched shot count.
module acq_window_ctrl
    import acq_pkg::*;
#(
    parameter int CNT_W  = ACQ_CNT_W,
    parameter int SHOT_W = ACQ_SHOT_W,
    parameter int MISS_W = ACQ_MISS_W
) (
    input  logic             clk,
    input  logic             rst,
    acq_window_ctrl_if.slave bus
);

    acq_state_t        r_state;
    acq_state_t        w_state_nxt;

    logic [CNT_W-1:0]  r_dly;
    logic [CNT_W-1:0]  r_len;
    logic [SHOT_W-1:0] r_shots;

    logic [CNT_W-1:0]  r_dly_cnt;
    logic [CNT_W-1:0]  w_dly_cnt_nxt;
    logic [CNT_W-1:0]  r_sample;
    logic [CNT_W-1:0]  w_sample_nxt;
    logic [SHOT_W-1:0] r_shot;
    logic [SHOT_W-1:0] w_shot_nxt;

    logic              w_latch;
    logic              w_miss_inc;
    logic              w_miss_clr;

    logic              r_window_en;
    logic              r_first;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    // Next-state, counter and missed-trigger decisions; abort overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_dly_cnt_nxt = r_dly_cnt;
        w_sample_nxt  = '0;
        w_shot_nxt    = r_shot;
        w_latch       = 1'b0;
        w_miss_inc    = 1'b0;
        w_miss_clr    = 1'b0;

        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        w_latch     = 1'b1;
                        w_miss_clr  = 1'b1;
                        w_shot_nxt  = '0;
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.trigger_start) begin
                        if (r_dly != '0) begin
                            w_dly_cnt_nxt = r_dly - CNT_W'(1);
                            w_state_nxt   = ST_DELAY;
                        end else begin
                            w_state_nxt   = ST_CAPTURE;
                        end
                    end
                end
                ST_DELAY: begin
                    w_miss_inc = bus.trigger_start;
                    if (r_dly_cnt == '0) begin
                        w_state_nxt = ST_CAPTURE;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    w_miss_inc = bus.trigger_start;
                    if (r_sample == (r_len - CNT_W'(1))) begin
                        if (r_shot == (r_shots - SHOT_W'(1))) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_shot_nxt  = r_shot + SHOT_W'(1);
                            w_state_nxt = ST_ARMED;
                        end
                    end else begin
                        w_sample_nxt = r_sample + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    w_miss_inc  = bus.trigger_start;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dly_cnt <= '0;
            r_sample  <= '0;
            r_shot    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dly_cnt <= w_dly_cnt_nxt;
            r_sample  <= w_sample_nxt;
            r_shot    <= w_shot_nxt;
        end
    end

    // Config is captured only on an accepted arm; zero length/shots become one here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly   <= '0;
            r_len   <= CNT_W'(1);
            r_shots <= SHOT_W'(1);
        end else if (w_latch) begin
            r_dly   <= bus.delay_cfg;
            r_len   <= (bus.length_cfg == '0) ? CNT_W'(1) : bus.length_cfg;
            r_shots <= (bus.shots_cfg == '0) ? SHOT_W'(1) : bus.shots_cfg;
        end
    end

    // Registered status outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window_en <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_window_en <= (w_state_nxt == ST_CAPTURE);
            r_first     <= (w_state_nxt == ST_CAPTURE) && (w_sample_nxt == '0);
            r_last      <= (w_state_nxt == ST_CAPTURE) && (w_sample_nxt == (r_len - CNT_W'(1)));
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    acq_sat_counter #(
        .W (MISS_W)
    ) u_missed_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_miss_clr),
        .i_inc (w_miss_inc),
        .o_cnt (bus.missed_cnt)
    );

    assign bus.window_en    = r_window_en;
    assign bus.first_sample = r_first;
    assign bus.last_sample  = r_last;
    assign bus.sample_idx   = r_sample;
    assign bus.shot_idx     = r_shot;
    assign bus.busy         = r_busy;
    assign bus.acq_done     = r_done;

endmodule
